// File: rtl/spi_arb_pkg.sv
// Shared types and width helpers for the SPI transaction arbiter.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SEND,
    ST_WAIT_RX,
    ST_WAIT_CS,
    ST_DONE
  } arb_state_t;

  // Width of a byte counter able to hold 0..max_bytes.
  function automatic int cnt_w(input int max_bytes);
    return $clog2(max_bytes + 1);
  endfunction

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requester at or after ptr, wrapping around.
module rr_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  // Scan offsets from the far end down so the closest hit to ptr is kept last.
  always_comb begin
    int sum;
    logic [IDX_W-1:0] pos;
    sum       = 0;
    pos       = '0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      sum = int'(ptr) + off;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      pos = IDX_W'(sum);
      if (req[pos]) begin
        grant      = '0;
        grant[pos] = 1'b1;
        grant_idx  = pos;
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one SPI byte controller between several requesters, one whole
// chip-select transaction at a time, with a per-byte rx watchdog.
module spi_txn_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ          = 4,
  parameter int MAX_BYTES_PER_CS = 2,
  parameter int TIMEOUT_CYC      = 1024,
  localparam int CNT_W = cnt_w(MAX_BYTES_PER_CS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*CNT_W-1:0] req_count,
  input  logic [NUM_REQ*8-1:0]     req_tx_byte,
  output logic [NUM_REQ-1:0]       req_ack,
  output logic                     req_err,
  output logic [NUM_REQ-1:0]       tx_pop,
  output logic [NUM_REQ-1:0]       rx_valid,
  output logic [7:0]               rx_byte,
  output logic                     busy,
  output logic [CNT_W-1:0]         ctl_tx_count,
  output logic [7:0]               ctl_tx_byte,
  output logic                     ctl_tx_dv,
  input  logic                     ctl_tx_ready,
  input  logic                     ctl_rx_dv,
  input  logic [7:0]               ctl_rx_byte,
  input  logic                     ctl_spi_cs_n
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

  arb_state_t         state;
  logic [IDX_W-1:0]   owner;
  logic [NUM_REQ-1:0] owner_oh;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   rx_cnt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [WD_W-1:0]    watchdog;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;
  logic [IDX_W-1:0]   next_ptr;
  logic               count_bad;

  logic [7:0]       tx_bytes [NUM_REQ];
  logic [CNT_W-1:0] counts   [NUM_REQ];

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Split the flat per-requester buses into indexable arrays.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      tx_bytes[i] = req_tx_byte[i*8 +: 8];
      counts[i]   = req_count[i*CNT_W +: CNT_W];
    end
  end

  assign next_ptr  = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  assign count_bad = (count == '0) || (count > CNT_W'(MAX_BYTES_PER_CS));

  // Transaction FSM; all outputs are registered and pulses self-clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      owner        <= '0;
      owner_oh     <= '0;
      count        <= '0;
      rx_cnt       <= '0;
      rr_ptr       <= '0;
      watchdog     <= '0;
      req_ack      <= '0;
      req_err      <= 1'b0;
      tx_pop       <= '0;
      rx_valid     <= '0;
      rx_byte      <= '0;
      busy         <= 1'b0;
      ctl_tx_count <= '0;
      ctl_tx_byte  <= '0;
      ctl_tx_dv    <= 1'b0;
    end else begin
      req_ack   <= '0;
      req_err   <= 1'b0;
      tx_pop    <= '0;
      rx_valid  <= '0;
      ctl_tx_dv <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            owner    <= grant_idx;
            owner_oh <= grant;
            count    <= counts[grant_idx];
            rx_cnt   <= '0;
            busy     <= 1'b1;
            state    <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (count_bad) begin
            req_ack <= owner_oh;
            req_err <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            ctl_tx_count <= count;
            state        <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (ctl_tx_ready && !ctl_tx_dv) begin
            ctl_tx_dv   <= 1'b1;
            ctl_tx_byte <= tx_bytes[owner];
            tx_pop      <= owner_oh;
            watchdog    <= WD_W'(TIMEOUT_CYC);
            state       <= ST_WAIT_RX;
          end
        end
        ST_WAIT_RX: begin
          if (ctl_rx_dv) begin
            rx_byte  <= ctl_rx_byte;
            rx_valid <= owner_oh;
            rx_cnt   <= rx_cnt + 1'b1;
            state    <= (rx_cnt + 1'b1 == count) ? ST_WAIT_CS : ST_SEND;
          end else if (watchdog <= WD_W'(1)) begin
            req_ack      <= owner_oh;
            req_err      <= 1'b1;
            rr_ptr       <= next_ptr;
            busy         <= 1'b0;
            ctl_tx_count <= '0;
            state        <= ST_IDLE;
          end else begin
            watchdog <= watchdog - 1'b1;
          end
        end
        ST_WAIT_CS: begin
          if (ctl_spi_cs_n) state <= ST_DONE;
        end
        ST_DONE: begin
          req_ack      <= owner_oh;
          rr_ptr       <= next_ptr;
          busy         <= 1'b0;
          ctl_tx_count <= '0;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Self-checking bench for spi_txn_arbiter with a behavioural controller
// and an order/outcome reference model.
module tb_spi_txn_arbiter;

  localparam int NUM_REQ = 4;
  localparam int MAX_B   = 2;
  localparam int TMO     = 16;
  localparam int CNT_W   = 2;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*CNT_W-1:0] req_count;
  logic [NUM_REQ*8-1:0]     req_tx_byte;
  logic [NUM_REQ-1:0]       req_ack;
  logic                     req_err;
  logic [NUM_REQ-1:0]       tx_pop;
  logic [NUM_REQ-1:0]       rx_valid;
  logic [7:0]               rx_byte;
  logic                     busy;
  logic [CNT_W-1:0]         ctl_tx_count;
  logic [7:0]               ctl_tx_byte;
  logic                     ctl_tx_dv;
  logic                     ctl_tx_ready;
  logic                     ctl_rx_dv;
  logic [7:0]               ctl_rx_byte;
  logic                     ctl_spi_cs_n;

  spi_txn_arbiter #(
    .NUM_REQ          (NUM_REQ),
    .MAX_BYTES_PER_CS (MAX_B),
    .TIMEOUT_CYC      (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_count    (req_count),
    .req_tx_byte  (req_tx_byte),
    .req_ack      (req_ack),
    .req_err      (req_err),
    .tx_pop       (tx_pop),
    .rx_valid     (rx_valid),
    .rx_byte      (rx_byte),
    .busy         (busy),
    .ctl_tx_count (ctl_tx_count),
    .ctl_tx_byte  (ctl_tx_byte),
    .ctl_tx_dv    (ctl_tx_dv),
    .ctl_tx_ready (ctl_tx_ready),
    .ctl_rx_dv    (ctl_rx_dv),
    .ctl_rx_byte  (ctl_rx_byte),
    .ctl_spi_cs_n (ctl_spi_cs_n)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int start_tick = 0;
  int mdl_ptr    = 0;

  logic [7:0] tx_data [NUM_REQ][4];
  int         byte_pos [NUM_REQ];
  int         cnt_cfg  [NUM_REQ];

  bit         respond;
  bit         stray_pulse;
  bit         rx_pending;
  bit         cs_pend;
  int         rx_delay;
  int         cs_delay;
  int         bytes_done;
  int         cs_rise_tick;
  logic [7:0] rx_data;

  int ack_idx_q[$], ack_err_q[$], ack_tick_q[$];
  int rx_idx_q[$], rx_byte_q[$], pop_idx_q[$];
  int dv_byte_q[$], dv_cnt_q[$], dv_tick_q[$];

  function automatic int oh2idx(input logic [NUM_REQ-1:0] v);
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int qget(input int q[$], input int k);
    if (k < q.size()) return q[k];
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic driveRequesters();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_tx_byte[i*8 +: 8]       = tx_data[i][(byte_pos[i] < 4) ? byte_pos[i] : 3];
      req_count[i*CNT_W +: CNT_W] = CNT_W'(cnt_cfg[i]);
    end
  endtask

  task automatic clearQueues();
    ack_idx_q.delete(); ack_err_q.delete(); ack_tick_q.delete();
    rx_idx_q.delete();  rx_byte_q.delete(); pop_idx_q.delete();
    dv_byte_q.delete(); dv_cnt_q.delete();  dv_tick_q.delete();
  endtask

  // One clock: observe DUT outputs at the falling edge, then advance the
  // requesters and the controller model and drive the next inputs.
  task automatic applyStimulus();
    int idx;
    @(negedge clk);
    cyc++;
    if (req_ack != '0) begin
      checkOutput("ack_onehot", $countones(req_ack), 1);
      ack_idx_q.push_back(oh2idx(req_ack));
      ack_err_q.push_back(int'(req_err));
      ack_tick_q.push_back(cyc);
      req_valid = req_valid & ~req_ack;
    end
    if (tx_pop != '0) begin
      idx = oh2idx(tx_pop);
      pop_idx_q.push_back(idx);
      if (idx >= 0) byte_pos[idx]++;
    end
    if (rx_valid != '0) begin
      rx_idx_q.push_back(oh2idx(rx_valid));
      rx_byte_q.push_back(int'(rx_byte));
    end
    if (ctl_tx_dv) begin
      dv_byte_q.push_back(int'(ctl_tx_byte));
      dv_cnt_q.push_back(int'(ctl_tx_count));
      dv_tick_q.push_back(cyc);
    end

    ctl_rx_dv = 1'b0;
    if (rst || !busy) begin
      rx_pending   = 1'b0;
      cs_pend      = 1'b0;
      bytes_done   = 0;
      ctl_spi_cs_n = 1'b1;
    end else if (ctl_tx_dv) begin
      ctl_spi_cs_n = 1'b0;
      if (respond) begin
        rx_pending = 1'b1;
        rx_delay   = int'($urandom_range(0, 3));
        rx_data    = ~ctl_tx_byte;
      end
    end else if (rx_pending) begin
      if (rx_delay == 0) begin
        ctl_rx_dv   = 1'b1;
        ctl_rx_byte = rx_data;
        rx_pending  = 1'b0;
        bytes_done++;
        if (bytes_done == int'(ctl_tx_count)) begin
          cs_pend  = 1'b1;
          cs_delay = int'($urandom_range(1, 3));
        end
      end else begin
        rx_delay--;
      end
    end else if (cs_pend) begin
      if (cs_delay == 0) begin
        ctl_spi_cs_n = 1'b1;
        cs_pend      = 1'b0;
        bytes_done   = 0;
        cs_rise_tick = cyc;
      end else begin
        cs_delay--;
      end
    end
    if (stray_pulse) begin
      ctl_rx_dv   = 1'b1;
      ctl_rx_byte = 8'hEE;
    end
    ctl_tx_ready = ($urandom_range(0, 3) != 0);
    driveRequesters();
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_req_ack"},      32'(req_ack),      0);
    checkOutput({tag, "_req_err"},      32'(req_err),      0);
    checkOutput({tag, "_tx_pop"},       32'(tx_pop),       0);
    checkOutput({tag, "_rx_valid"},     32'(rx_valid),     0);
    checkOutput({tag, "_rx_byte"},      32'(rx_byte),      0);
    checkOutput({tag, "_busy"},         32'(busy),         0);
    checkOutput({tag, "_ctl_tx_count"}, 32'(ctl_tx_count), 0);
    checkOutput({tag, "_ctl_tx_byte"},  32'(ctl_tx_byte),  0);
    checkOutput({tag, "_ctl_tx_dv"},    32'(ctl_tx_dv),    0);
  endtask

  task automatic doReset(input string tag);
    rst       = 1'b1;
    req_valid = '0;
    repeat (3) applyStimulus();
    checkIdleOutputs(tag);
    rst     = 1'b0;
    mdl_ptr = 0;
  endtask

  task automatic startRequests(input logic [NUM_REQ-1:0] mask);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (mask[i]) begin
        req_valid[i] = 1'b1;
        byte_pos[i]  = 0;
      end
    end
    driveRequesters();
    start_tick = cyc;
  endtask

  task automatic waitAcks(input int n, input int budget);
    int left;
    left = budget;
    while (ack_idx_q.size() < n && left > 0) begin
      applyStimulus();
      left--;
    end
    if (ack_idx_q.size() < n) checkOutput("ack_wait_expired", ack_idx_q.size(), n);
  endtask

  // Issue requests from every requester in mask and compare the whole
  // outcome with the reference: grant order by round robin from the model
  // pointer, rejects for bad counts, inverted echo for good ones.
  task automatic doRound(input logic [NUM_REQ-1:0] mask);
    int e_ack_idx[$], e_ack_err[$], e_rx_idx[$], e_rx_byte[$];
    int e_dv_byte[$], e_dv_cnt[$];
    logic [NUM_REQ-1:0] rem;
    logic [7:0] b;
    int ptr, p, n;
    bit bad;
    clearQueues();
    startRequests(mask);
    waitAcks($countones(mask), 600);

    ptr = mdl_ptr;
    rem = mask;
    while (rem != '0) begin
      p = -1;
      for (int off = 0; off < NUM_REQ && p < 0; off++)
        if (rem[(ptr + off) % NUM_REQ]) p = (ptr + off) % NUM_REQ;
      rem[p] = 1'b0;
      bad = (cnt_cfg[p] == 0) || (cnt_cfg[p] > MAX_B);
      e_ack_idx.push_back(p);
      e_ack_err.push_back(bad ? 1 : 0);
      if (!bad) begin
        for (int j = 0; j < cnt_cfg[p]; j++) begin
          b = ~tx_data[p][j];
          e_rx_idx.push_back(p);
          e_rx_byte.push_back(int'(b));
          e_dv_byte.push_back(int'(tx_data[p][j]));
          e_dv_cnt.push_back(cnt_cfg[p]);
        end
        ptr = (p + 1) % NUM_REQ;
      end
    end
    mdl_ptr = ptr;

    checkOutput("round_ack_count", ack_idx_q.size(), e_ack_idx.size());
    checkOutput("round_rx_count",  rx_idx_q.size(),  e_rx_idx.size());
    checkOutput("round_dv_count",  dv_byte_q.size(), e_dv_byte.size());
    checkOutput("round_pop_count", pop_idx_q.size(), e_rx_idx.size());
    n = e_ack_idx.size();
    for (int k = 0; k < n && k < ack_idx_q.size(); k++) begin
      checkOutput("round_ack_idx", ack_idx_q[k], e_ack_idx[k]);
      checkOutput("round_ack_err", ack_err_q[k], e_ack_err[k]);
    end
    n = e_rx_idx.size();
    for (int k = 0; k < n && k < rx_idx_q.size(); k++) begin
      checkOutput("round_rx_idx",  rx_idx_q[k],  e_rx_idx[k]);
      checkOutput("round_rx_byte", rx_byte_q[k], e_rx_byte[k]);
    end
    for (int k = 0; k < n && k < pop_idx_q.size(); k++)
      checkOutput("round_pop_idx", pop_idx_q[k], e_rx_idx[k]);
    for (int k = 0; k < n && k < dv_byte_q.size(); k++) begin
      checkOutput("round_dv_byte", dv_byte_q[k], e_dv_byte[k]);
      checkOutput("round_dv_cnt",  dv_cnt_q[k],  e_dv_cnt[k]);
    end
  endtask

  initial begin
    int left;
    logic [7:0] b;
    req_valid    = '0;
    req_count    = '0;
    req_tx_byte  = '0;
    ctl_tx_ready = 1'b1;
    ctl_rx_dv    = 1'b0;
    ctl_rx_byte  = '0;
    ctl_spi_cs_n = 1'b1;
    respond      = 1'b1;
    stray_pulse  = 1'b0;
    rx_pending   = 1'b0;
    cs_pend      = 1'b0;
    rx_delay     = 0;
    cs_delay     = 0;
    bytes_done   = 0;
    cs_rise_tick = 0;
    rx_data      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      byte_pos[i] = 0;
      cnt_cfg[i]  = 1;
      for (int j = 0; j < 4; j++) tx_data[i][j] = 8'(i * 16 + j);
    end

    // Single two-byte transaction with inverted echo.
    doReset("rst0");
    tx_data[0][0] = 8'hA5;
    tx_data[0][1] = 8'h3C;
    cnt_cfg[0]    = 2;
    doRound(4'b0001);
    checkOutput("t1_rx0", qget(rx_byte_q, 0), 32'h5A);
    checkOutput("t1_rx1", qget(rx_byte_q, 1), 32'hC3);
    checkOutput("t1_ack_err", qget(ack_err_q, 0), 0);
    checkOutput("t1_ack_after_cs", qget(ack_tick_q, 0) - cs_rise_tick, 2);
    checkOutput("t1_dv_latency", 32'((qget(dv_tick_q, 0) - start_tick) >= 3), 1);

    // All four at once, then a partial re-request.
    doReset("rst1");
    for (int i = 0; i < NUM_REQ; i++) cnt_cfg[i] = 1;
    doRound(4'b1111);
    for (int k = 0; k < 4; k++) checkOutput("t2_order_all", qget(ack_idx_q, k), k);
    doRound(4'b0101);
    checkOutput("t2_order_a", qget(ack_idx_q, 0), 0);
    checkOutput("t2_order_b", qget(ack_idx_q, 1), 2);

    // Zero and oversized counts are rejected without controller traffic.
    doReset("rst2");
    cnt_cfg[0] = 0;
    doRound(4'b0001);
    checkOutput("t3_zero_err",  qget(ack_err_q, 0), 1);
    checkOutput("t3_zero_lat",  qget(ack_tick_q, 0) - start_tick, 2);
    checkOutput("t3_zero_nodv", dv_byte_q.size(), 0);
    cnt_cfg[1] = 3;
    doRound(4'b0010);
    checkOutput("t3_big_err",  qget(ack_err_q, 0), 1);
    checkOutput("t3_big_lat",  qget(ack_tick_q, 0) - start_tick, 2);
    checkOutput("t3_big_nodv", dv_byte_q.size(), 0);

    // Silent controller: watchdog abort, then the next requester is served.
    doReset("rst3");
    cnt_cfg[1] = 1;
    cnt_cfg[2] = 1;
    respond    = 1'b0;
    clearQueues();
    startRequests(4'b0110);
    waitAcks(1, 200);
    respond = 1'b1;
    waitAcks(2, 200);
    checkOutput("t4_to_idx",  qget(ack_idx_q, 0), 1);
    checkOutput("t4_to_err",  qget(ack_err_q, 0), 1);
    checkOutput("t4_to_lat",  qget(ack_tick_q, 0) - qget(dv_tick_q, 0), TMO);
    checkOutput("t4_pop1",    qget(pop_idx_q, 0), 1);
    checkOutput("t4_next_idx", qget(ack_idx_q, 1), 2);
    checkOutput("t4_next_err", qget(ack_err_q, 1), 0);
    b = ~tx_data[2][0];
    checkOutput("t4_next_rx", qget(rx_byte_q, 0), 32'(b));

    // Reset while waiting for rx: immediate clear, no ack, clean restart.
    doReset("rst4");
    cnt_cfg[3] = 2;
    respond    = 1'b0;
    clearQueues();
    startRequests(4'b1000);
    left = 50;
    while (dv_byte_q.size() == 0 && left > 0) begin
      applyStimulus();
      left--;
    end
    checkOutput("t5_dv_seen", dv_byte_q.size(), 1);
    repeat (2) applyStimulus();
    rst = 1'b1;
    #1;
    checkIdleOutputs("t5_async");
    repeat (3) applyStimulus();
    rst       = 1'b0;
    req_valid = '0;
    repeat (2) applyStimulus();
    checkOutput("t5_no_ack", ack_idx_q.size(), 0);
    mdl_ptr = 0;
    respond = 1'b1;
    doRound(4'b1000);

    // Stray controller rx strobe while idle.
    clearQueues();
    stray_pulse = 1'b1;
    applyStimulus();
    stray_pulse = 1'b0;
    repeat (3) applyStimulus();
    checkOutput("t6_no_rx", rx_idx_q.size(), 0);
    checkOutput("t6_idle",  32'(busy), 0);

    // Randomized rounds against the reference model.
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_cfg[i] = int'($urandom_range(0, 3));
        for (int j = 0; j < 4; j++) tx_data[i][j] = 8'($urandom);
      end
      doRound(NUM_REQ'($urandom_range(1, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
